// File: rtl/cpu_trace_pkg.sv
// Shared definitions for the CPU trace buffer: record layout and serializer states.
package cpu_trace_pkg;

    localparam int TRACE_REC_W = 24;

    // Field LSB positions inside a trace record {pc, instr, R0, R1, ram3}
    localparam int PC_LSB    = 20;
    localparam int INSTR_LSB = 12;
    localparam int R0_LSB    = 8;
    localparam int R1_LSB    = 4;
    localparam int RAM3_LSB  = 0;

    // Stream byte boundaries: each byte is an aligned 8-bit slice of the record
    localparam int BYTE0_LSB = 16;
    localparam int BYTE1_LSB = 8;
    localparam int BYTE2_LSB = 0;

    typedef enum logic [1:0] {
        SER_IDLE = 2'd0,
        SER_B0   = 2'd1,
        SER_B1   = 2'd2,
        SER_B2   = 2'd3
    } ser_state_t;

    function automatic logic [TRACE_REC_W-1:0] pack_rec(
        input logic [3:0] pc,
        input logic [7:0] instr,
        input logic [3:0] r0,
        input logic [3:0] r1,
        input logic [3:0] ram3
    );
        return {pc, instr, r0, r1, ram3};
    endfunction

endpackage

// File: rtl/cpu_trace_buffer_fifo.sv
// Generic synchronous FIFO with extra-MSB pointers for full/empty distinction.
module trace_fifo #(
    parameter int DATA_W = 24,
    parameter int DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DATA_W-1:0]        wr_data,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic              do_push;
    logic              do_pop;

    // A push into a full FIFO is only legal when the head leaves on the same edge
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level   = wr_ptr - rd_ptr;
    assign rd_data = mem[rd_ptr[AW-1:0]];

    // Storage array; payload carries no reset
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    // Read/write pointers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/cpu_trace_buffer.sv
// CPU trace buffer: change-detected capture of CPU debug state into a FIFO,
// drained as a 3-byte valid/ready stream per record.
module cpu_trace_buffer
    import cpu_trace_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     trace_en,
    input  logic                     clear,
    input  logic [3:0]               pc_debug,
    input  logic [7:0]               instr_debug,
    input  logic [3:0]               R0_debug,
    input  logic [3:0]               R1_debug,
    input  logic [3:0]               ram3_debug,
    output logic [7:0]               out_data,
    output logic                     out_valid,
    output logic                     out_last,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     overflow,
    output logic [CNT_W-1:0]         drop_count
);

    logic [TRACE_REC_W-1:0] cur_rec;
    logic [TRACE_REC_W-1:0] last_rec;
    logic [TRACE_REC_W-1:0] hold_rec;
    logic [TRACE_REC_W-1:0] fifo_rd;
    logic                   last_vld;
    logic                   capture;
    logic                   push;
    logic                   pop;
    logic                   drop;
    logic                   fifo_full;
    logic                   fifo_empty;
    ser_state_t             state;
    ser_state_t             state_nxt;

    assign cur_rec = pack_rec(pc_debug, instr_debug, R0_debug, R1_debug, ram3_debug);

    // Capture only on architectural change; an invalid last record forces capture
    assign capture = trace_en && (!last_vld || (cur_rec != last_rec));
    // A pop on the same edge frees a slot, so a full FIFO can still accept
    assign push    = capture && (!fifo_full || pop);
    assign drop    = capture && fifo_full && !pop;

    trace_fifo #(
        .DATA_W (TRACE_REC_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .pop     (pop),
        .wr_data (cur_rec),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    // Last-record valid flag: disabling trace invalidates it so re-enable recaptures
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_vld <= 1'b0;
        end else if (!trace_en) begin
            last_vld <= 1'b0;
        end else if (capture) begin
            last_vld <= 1'b1;
        end
    end

    // Last-record payload, loaded on every capture even when the push is dropped
    always_ff @(posedge clk) begin
        if (capture) begin
            last_rec <= cur_rec;
        end
    end

    // Drop accounting: a drop in the same cycle as clear wins and restarts the count at 1
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (clear) begin
                drop_count <= {{(CNT_W-1){1'b0}}, 1'b1};
            end else if (drop_count != {CNT_W{1'b1}}) begin
                drop_count <= drop_count + 1'b1;
            end
        end else if (clear) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end
    end

    // Serializer state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= SER_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Holding register for the record being streamed out
    always_ff @(posedge clk) begin
        if (pop) begin
            hold_rec <= fifo_rd;
        end
    end

    // Serializer next-state, pop request and stream outputs
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_data  = 8'h00;
        case (state)
            SER_IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    state_nxt = SER_B0;
                end
            end
            SER_B0: begin
                out_valid = 1'b1;
                out_data  = hold_rec[BYTE0_LSB +: 8];
                if (out_ready) begin
                    state_nxt = SER_B1;
                end
            end
            SER_B1: begin
                out_valid = 1'b1;
                out_data  = hold_rec[BYTE1_LSB +: 8];
                if (out_ready) begin
                    state_nxt = SER_B2;
                end
            end
            SER_B2: begin
                out_valid = 1'b1;
                out_last  = 1'b1;
                out_data  = hold_rec[BYTE2_LSB +: 8];
                if (out_ready) begin
                    if (!fifo_empty) begin
                        pop       = 1'b1;
                        state_nxt = SER_B0;
                    end else begin
                        state_nxt = SER_IDLE;
                    end
                end
            end
            default: begin
                state_nxt = SER_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Directed bench for cpu_trace_buffer with hand-computed expected stream bytes.
module tb_cpu_trace_buffer;

    localparam int DEPTH = 16;
    localparam int CNT_W = 8;

    logic             clk;
    logic             reset;
    logic             trace_en;
    logic             clear;
    logic [3:0]       pc_debug;
    logic [7:0]       instr_debug;
    logic [3:0]       R0_debug;
    logic [3:0]       R1_debug;
    logic [3:0]       ram3_debug;
    logic [7:0]       out_data;
    logic             out_valid;
    logic             out_last;
    logic             out_ready;
    logic [4:0]       fifo_level;
    logic             overflow;
    logic [CNT_W-1:0] drop_count;

    int n_checks;
    int n_fail;
    logic [8:0] bytes_q[$];

    cpu_trace_buffer #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .trace_en    (trace_en),
        .clear       (clear),
        .pc_debug    (pc_debug),
        .instr_debug (instr_debug),
        .R0_debug    (R0_debug),
        .R1_debug    (R1_debug),
        .ram3_debug  (ram3_debug),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_last    (out_last),
        .out_ready   (out_ready),
        .fifo_level  (fifo_level),
        .overflow    (overflow),
        .drop_count  (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Log every byte handed over; the handshake is stable at the falling edge
    always @(negedge clk) begin
        if (reset && out_valid && out_ready) begin
            bytes_q.push_back({out_last, out_data});
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [3:0] pc, input logic [7:0] ins,
                          input logic [3:0] r0, input logic [3:0] r1, input logic [3:0] r3);
        pc_debug    = pc;
        instr_debug = ins;
        R0_debug    = r0;
        R1_debug    = r1;
        ram3_debug  = r3;
    endtask

    initial begin
        int peak;
        logic [7:0] ins;
        logic [3:0] pcn;
        n_checks  = 0;
        n_fail    = 0;
        reset     = 1'b0;
        trace_en  = 1'b0;
        clear     = 1'b0;
        out_ready = 1'b0;
        set_in(4'h0, 8'h00, 4'h0, 4'h0, 4'h0);
        #23;
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_last", {31'd0, out_last}, 32'd0);
        check("rst_data", {24'd0, out_data}, 32'd0);
        check("rst_level", {27'd0, fifo_level}, 32'd0);
        check("rst_ovf", {31'd0, overflow}, 32'd0);
        check("rst_drops", {24'd0, drop_count}, 32'd0);
        tick();
        reset = 1'b1;
        tick();

        // Single record from constant inputs
        set_in(4'h2, 8'hA5, 4'h1, 4'h3, 4'h7);
        trace_en  = 1'b1;
        out_ready = 1'b1;
        tick();
        check("lat_k_valid", {31'd0, out_valid}, 32'd0);
        check("lat_k_level", {27'd0, fifo_level}, 32'd1);
        tick();
        check("lat_k1_valid", {31'd0, out_valid}, 32'd1);
        check("lat_k1_data", {24'd0, out_data}, 32'h2A);
        repeat (10) tick();
        check("one_count", bytes_q.size(), 32'd3);
        if (bytes_q.size() == 3) begin
            check("one_b0", {23'd0, bytes_q[0]}, {23'd0, 1'b0, 8'h2A});
            check("one_b1", {23'd0, bytes_q[1]}, {23'd0, 1'b0, 8'h51});
            check("one_b2", {23'd0, bytes_q[2]}, {23'd0, 1'b1, 8'h37});
        end
        bytes_q.delete();

        // Stepping PC 0..5
        peak = 0;
        for (int i = 0; i < 6; i++) begin
            pcn = 4'(i);
            set_in(pcn, 8'h10, 4'h0, 4'h0, 4'h0);
            tick();
            if (int'(fifo_level) > peak) peak = int'(fifo_level);
        end
        for (int i = 0; i < 30; i++) begin
            tick();
            if (int'(fifo_level) > peak) peak = int'(fifo_level);
        end
        check("step_count", bytes_q.size(), 32'd18);
        check("step_peak_le6", {31'd0, (peak <= 6)}, 32'd1);
        check("step_level_end", {27'd0, fifo_level}, 32'd0);
        if (bytes_q.size() == 18) begin
            for (int r = 0; r < 6; r++) begin
                pcn = 4'(r);
                check($sformatf("step_r%0d_b0", r), {23'd0, bytes_q[3*r]}, {23'd0, 1'b0, pcn, 4'h1});
                check($sformatf("step_r%0d_b1", r), {23'd0, bytes_q[3*r+1]}, {23'd0, 9'h000});
                check($sformatf("step_r%0d_b2", r), {23'd0, bytes_q[3*r+2]}, {23'd0, 9'h100});
            end
        end
        bytes_q.delete();

        // Overflow with a stalled sink
        out_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            pcn = 4'(i);
            ins = 8'h40 + 8'(i);
            set_in(pcn, ins, 4'h0, 4'h0, 4'h0);
            tick();
        end
        check("ovf_level", {27'd0, fifo_level}, 32'd16);
        check("ovf_flag", {31'd0, overflow}, 32'd1);
        check("ovf_drops", {24'd0, drop_count}, 32'd3);
        check("ovf_valid", {31'd0, out_valid}, 32'd1);
        check("ovf_data", {24'd0, out_data}, 32'h04);
        repeat (3) tick();
        check("stall_data", {24'd0, out_data}, 32'h04);
        check("stall_last", {31'd0, out_last}, 32'd0);
        check("stall_nobytes", bytes_q.size(), 32'd0);
        out_ready = 1'b1;
        repeat (70) tick();
        check("drain_count", bytes_q.size(), 32'd51);
        check("drain_level", {27'd0, fifo_level}, 32'd0);
        if (bytes_q.size() == 51) begin
            for (int k = 0; k < 17; k++) begin
                pcn = 4'(k);
                ins = 8'h40 + 8'(k);
                check($sformatf("drain_r%0d_b0", k), {23'd0, bytes_q[3*k]}, {23'd0, 1'b0, pcn, ins[7:4]});
                check($sformatf("drain_r%0d_b1", k), {23'd0, bytes_q[3*k+1]}, {23'd0, 1'b0, ins[3:0], 4'h0});
                check($sformatf("drain_r%0d_b2", k), {23'd0, bytes_q[3*k+2]}, {23'd0, 9'h100});
            end
        end
        bytes_q.delete();

        // Clear colliding with a drop
        out_ready = 1'b0;
        for (int i = 0; i < 18; i++) begin
            pcn = 4'(i);
            ins = 8'h80 + 8'(i);
            set_in(pcn, ins, 4'h0, 4'h0, 4'h0);
            clear = (i == 17);
            tick();
        end
        clear = 1'b0;
        check("clr_hit_ovf", {31'd0, overflow}, 32'd1);
        check("clr_hit_drops", {24'd0, drop_count}, 32'd1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_ovf", {31'd0, overflow}, 32'd0);
        check("clr_drops", {24'd0, drop_count}, 32'd0);
        check("clr_level", {27'd0, fifo_level}, 32'd16);
        out_ready = 1'b1;
        repeat (70) tick();
        check("clr_drain_count", bytes_q.size(), 32'd51);
        check("clr_drain_level", {27'd0, fifo_level}, 32'd0);
        bytes_q.delete();

        // Re-enable with identical inputs recaptures the same record
        trace_en = 1'b0;
        tick();
        trace_en = 1'b1;
        repeat (10) tick();
        check("reen_count", bytes_q.size(), 32'd3);
        if (bytes_q.size() == 3) begin
            check("reen_b0", {23'd0, bytes_q[0]}, {23'd0, 9'h019});
            check("reen_b1", {23'd0, bytes_q[1]}, {23'd0, 9'h010});
            check("reen_b2", {23'd0, bytes_q[2]}, {23'd0, 9'h100});
        end
        bytes_q.delete();

        // Asynchronous reset while the serializer sits in B1
        out_ready = 1'b0;
        set_in(4'h6, 8'h91, 4'h0, 4'h0, 4'h0);
        tick();
        set_in(4'h7, 8'h91, 4'h0, 4'h0, 4'h0);
        tick();
        set_in(4'h8, 8'h91, 4'h0, 4'h0, 4'h0);
        tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("b1_valid", {31'd0, out_valid}, 32'd1);
        check("b1_data", {24'd0, out_data}, 32'h10);
        check("b1_level", {27'd0, fifo_level}, 32'd2);
        #2;
        reset = 1'b0;
        #1;
        check("arst_valid", {31'd0, out_valid}, 32'd0);
        check("arst_level", {27'd0, fifo_level}, 32'd0);
        check("arst_data", {24'd0, out_data}, 32'd0);
        tick();
        reset = 1'b1;
        bytes_q.delete();
        out_ready = 1'b1;
        repeat (10) tick();
        check("post_rst_count", bytes_q.size(), 32'd3);
        if (bytes_q.size() == 3) begin
            check("post_rst_b0", {23'd0, bytes_q[0]}, {23'd0, 9'h089});
            check("post_rst_b2", {23'd0, bytes_q[2]}, {23'd0, 9'h100});
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
